// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Holds the fetch FSM state encoding and the branch-offset helper.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        RESET,
        FETCH,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    // Sign-extended 16-bit branch immediate, scaled from words to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave): one outstanding word request, ready-terminated.
interface mips_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );

endinterface

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection for a retiring instruction: jr/jalr, j/jal,
// taken conditional branch, or sequential. Jumps take priority over branches.
module mips_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [25:0] inst,
    input  logic [31:0] inst_pc,
    input  logic        ctrl_isbranch,
    input  logic        ctrl_isjump,
    input  logic        ctrl_jalr,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        misalign
);

    logic [31:0] seq;

    assign seq = inst_pc + INST_BYTES;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
        next_pc  = seq;
        taken    = 1'b0;
        misalign = 1'b0;
        if (ctrl_isjump) begin
            taken = 1'b1;
            if (ctrl_jalr) begin
                next_pc  = {jr_target[31:2], 2'b00};
                misalign = |jr_target[1:0];
            end else begin
                next_pc = {seq[31:28], inst[25:0], 2'b00};
            end
        end else if (ctrl_isbranch && br_taken) begin
            taken   = 1'b1;
            next_pc = seq + branch_offset(inst[15:0]);
        end
    end

endmodule

// File: rtl/mips_fetch.sv
// MIPS instruction-fetch stage: PC register, fetch FSM, instruction latch and
// next-PC update on retire. Define MIPS_DELAY_SLOT_EN for branch-delay-slot semantics.
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    mips_fetch_if.master imem,
    output logic         inst_valid,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    input  logic         inst_ack,
    input  logic         ctrl_isbranch,
    input  logic         ctrl_isjump,
    input  logic         ctrl_jalr,
    input  logic         br_taken,
    input  logic [31:0]  jr_target,
    input  logic         halt,
    output logic         pc_misalign
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         fetch_req;
    logic         retire;
    logic [31:0]  seq;
    logic [31:0]  target_pc;
    logic         target_taken;
    logic         target_misalign;
    logic [31:0]  retire_pc;
    logic         misalign_hit;

    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = pc;
    assign retire         = (state == HOLD) && inst_ack;
    assign seq            = inst_pc + INST_BYTES;

    mips_next_pc u_next_pc (
        .inst          (inst[25:0]),
        .inst_pc       (inst_pc),
        .ctrl_isbranch (ctrl_isbranch),
        .ctrl_isjump   (ctrl_isjump),
        .ctrl_jalr     (ctrl_jalr),
        .br_taken      (br_taken),
        .jr_target     (jr_target),
        .next_pc       (target_pc),
        .taken         (target_taken),
        .misalign      (target_misalign)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
        if (rst) begin
            state       <= RESET;
            pc          <= RESET_PC;
            fetch_req   <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            pc_misalign <= 1'b0;
        end else begin
            case (state)
                RESET: begin
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_rdy) begin
                        inst       <= imem.imem_rdata;
                        inst_pc    <= pc;
                        fetch_req  <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ack) begin
                        pc         <= retire_pc;
                        inst_valid <= 1'b0;
                        if (misalign_hit) begin
                            pc_misalign <= 1'b1;
                        end
                        // A syscall still moves the PC but never issues another request.
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            state     <= FETCH;
                            fetch_req <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    fetch_req  <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: begin
                    state      <= RESET;
                    fetch_req  <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIPS_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        pend_valid_d;
    logic [31:0] pend_target_d;

    // A retiring slot always follows the pending target; transfers inside it are dropped.
    always_comb begin
        retire_pc     = seq;
        misalign_hit  = 1'b0;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        if (pend_valid) begin
            retire_pc    = pend_target;
            pend_valid_d = 1'b0;
        end else if (target_taken && !halt) begin
            retire_pc     = seq;
            misalign_hit  = target_misalign;
            pend_valid_d  = 1'b1;
            pend_target_d = target_pc;
        end else begin
            retire_pc    = target_taken ? target_pc : seq;
            misalign_hit = target_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (retire) begin
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
        end
    end
`else
    always_comb begin
        retire_pc    = target_taken ? target_pc : seq;
        misalign_hit = retire && target_misalign;
    end
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed scenarios plus randomized
// traffic compared against a behavioural next-PC model.
module tb_mips_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ack;
    logic        ctrl_isbranch;
    logic        ctrl_isjump;
    logic        ctrl_jalr;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        halt;
    logic        pc_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_fetch_if imem ();

    mips_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ack      (inst_ack),
        .ctrl_isbranch (ctrl_isbranch),
        .ctrl_isjump   (ctrl_isjump),
        .ctrl_jalr     (ctrl_jalr),
        .br_taken      (br_taken),
        .jr_target     (jr_target),
        .halt          (halt),
        .pc_misalign   (pc_misalign)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_inst_pc;
    logic [31:0] m_word;
    bit          m_misalign;
    logic [31:0] m_pending[$];

    function automatic logic [31:0] spec_target(input logic [31:0] pc, input logic [31:0] word,
                                                input bit isb, input bit isj, input bit jalr,
                                                input bit brt, input logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (isj && jalr) return jr - (jr % 32'd4);
        if (isj) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (isb && brt) begin
            off = int'($signed(word[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_misalign = 0;
        m_pending.delete();
    endtask

    task automatic model_retire(input bit isb, input bit isj, input bit jalr, input bit brt,
                                input logic [31:0] jr, input bit hlt);
        logic [31:0] tgt;
        bit          is_taken;
        bit          bad;
        tgt      = spec_target(m_inst_pc, m_word, isb, isj, jalr, brt, jr);
        is_taken = isj || (isb && brt);
        bad      = isj && jalr && ((jr % 32'd4) != 0);
`ifdef MIPS_DELAY_SLOT_EN
        if (m_pending.size() > 0) begin
            m_pc = m_pending.pop_front();
        end else if (is_taken && !hlt) begin
            m_pending.push_back(tgt);
            m_pc = m_inst_pc + 32'd4;
            if (bad) m_misalign = 1;
        end else begin
            m_pc = tgt;
            if (bad) m_misalign = 1;
        end
`else
        m_pc = tgt;
        if (bad) m_misalign = 1;
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        inst_ack      = 1'b0;
        ctrl_isbranch = 1'($urandom);
        ctrl_isjump   = 1'($urandom);
        ctrl_jalr     = 1'($urandom);
        br_taken      = 1'($urandom);
        jr_target     = $urandom;
        halt          = 1'($urandom);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        imem.imem_rdy   = 1'b0;
        imem.imem_rdata = $urandom;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Waits for a request, serves it after 'waits' stall cycles; ok=0 on timeout or unstable address.
    task automatic fetch_one(input logic [31:0] word, input int waits,
                             output logic [31:0] addr, output bit ok);
        int n;
        n    = 0;
        ok   = 0;
        addr = 'x;
        while (imem.imem_req !== 1'b1 && n < 40) begin
            inst_ack      = 1'($urandom);
            imem.imem_rdy = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (imem.imem_req !== 1'b1) return;
        addr = imem.imem_addr;
        ok   = 1;
        for (int i = 0; i < waits; i++) begin
            imem.imem_rdy   = 1'b0;
            imem.imem_rdata = $urandom;
            inst_ack        = 1'($urandom);
            @(negedge clk);
            if (imem.imem_addr !== addr || imem.imem_req !== 1'b1) ok = 0;
        end
        imem.imem_rdy   = 1'b1;
        imem.imem_rdata = word;
        @(negedge clk);
        idle_inputs();
        imem.imem_rdy   = 1'b0;
        imem.imem_rdata = $urandom;
        m_inst_pc = addr;
        m_word    = word;
    endtask

    task automatic retire_one(input int delay, input bit isb, input bit isj, input bit jalr,
                              input bit brt, input logic [31:0] jr, input bit hlt);
        for (int i = 0; i < delay; i++) begin
            idle_inputs();
            imem.imem_rdy = 1'($urandom);
            @(negedge clk);
        end
        imem.imem_rdy = 1'($urandom);
        inst_ack      = 1'b1;
        ctrl_isbranch = isb;
        ctrl_isjump   = isj;
        ctrl_jalr     = jalr;
        br_taken      = brt;
        jr_target     = jr;
        halt          = hlt;
        @(negedge clk);
        idle_inputs();
        imem.imem_rdy = 1'b0;
        model_retire(isb, isj, jalr, brt, jr, hlt);
    endtask

    task automatic walk_to(input int n, output bit ok);
        logic [31:0] a;
        bit          o;
        apply_reset();
        ok = 1;
        for (int i = 0; i < n; i++) begin
            fetch_one($urandom, 0, a, o);
            ok &= o;
            retire_one(0, 0, 0, 0, 0, 32'h0, 0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst             = 1'b1;
        imem.imem_rdy   = 1'b1;
        imem.imem_rdata = $urandom;
        inst_ack        = 1'b1;
        halt            = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({imem.imem_req, inst_valid, pc_misalign} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: req/valid/misalign=%b expected 000",
                     {imem.imem_req, inst_valid, pc_misalign});
        end
        n_checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_inst: inst=%h inst_pc=%h expected 0/0", inst, inst_pc);
        end
        n_checks++;
        if (imem.imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_pc: got %h expected %h", imem.imem_addr, RESET_PC);
        end
        rst = 1'b0;
        idle_inputs();
        imem.imem_rdy = 1'b0;
        model_reset();
        n_checks++;
        if (imem.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_cycle_req: got %b expected 0", imem.imem_req);
        end
        @(negedge clk);
        n_checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_second_cycle_req: req=%b addr=%h expected 1/%h",
                     imem.imem_req, imem.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        logic [31:0] w;
        bit          ok;
        time         t_prev;
        time         t_now;
        apply_reset();
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            fetch_one(w, 0, a, ok);
            t_now = $time - 10;
            n_checks++;
            if (!ok || a !== RESET_PC + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_addr[%0d]: got %h ok=%0d expected %h", k, a, ok, RESET_PC + 32'(4 * k));
            end
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== w || inst_pc !== RESET_PC + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_inst[%0d]: valid=%b inst=%h pc=%h expected 1/%h/%h",
                         k, inst_valid, inst, inst_pc, w, RESET_PC + 32'(4 * k));
            end
            if (k > 0) begin
                n_checks++;
                if (t_now - t_prev !== 20) begin
                    n_fail++;
                    $display("FAIL seq_rate[%0d]: request spacing %0t expected 20", k, t_now - t_prev);
                end
            end
            t_prev = t_now;
            retire_one(0, 0, 0, 0, 0, 32'h0, 0);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        logic [31:0] exp_addr;
        bit          ok;
        for (int brt = 1; brt >= 0; brt--) begin
            walk_to(4, ok);
            fetch_one(32'h1000_0003, 0, a, ok);
            n_checks++;
            if (!ok || a !== 32'h0040_0010) begin
                n_fail++;
                $display("FAIL branch_src[%0d]: got %h expected 00400010", brt, a);
            end
            retire_one(0, 1, 0, 0, brt[0], $urandom, 0);
`ifdef MIPS_DELAY_SLOT_EN
            if (brt == 1) begin
                fetch_one($urandom, 0, a, ok);
                n_checks++;
                if (!ok || a !== 32'h0040_0014) begin
                    n_fail++;
                    $display("FAIL branch_slot: got %h expected 00400014", a);
                end
                retire_one(0, 0, 0, 0, 0, 32'h0, 0);
            end
`endif
            exp_addr = (brt == 1) ? 32'h0040_0020 : 32'h0040_0014;
            fetch_one($urandom, 1, a, ok);
            n_checks++;
            if (!ok || a !== exp_addr) begin
                n_fail++;
                $display("FAIL branch_target[%0d]: got %h expected %h", brt, a, exp_addr);
            end
        end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        bit          ok;
        for (int k = 0; k < 2; k++) begin
            walk_to(2, ok);
            fetch_one(32'h0810_0040, 0, a, ok);
            n_checks++;
            if (!ok || a !== 32'h0040_0008) begin
                n_fail++;
                $display("FAIL jump_src[%0d]: got %h expected 00400008", k, a);
            end
            // second pass also raises a taken branch, which the jump must override
            retire_one(k, k[0], 1, 0, k[0], $urandom, 0);
`ifdef MIPS_DELAY_SLOT_EN
            fetch_one($urandom, 0, a, ok);
            n_checks++;
            if (!ok || a !== 32'h0040_000C) begin
                n_fail++;
                $display("FAIL jump_slot[%0d]: got %h expected 0040000c", k, a);
            end
            retire_one(0, 0, 0, 0, 0, 32'h0, 0);
`endif
            fetch_one($urandom, 0, a, ok);
            n_checks++;
            if (!ok || a !== 32'h0040_0100) begin
                n_fail++;
                $display("FAIL jump_target[%0d]: got %h expected 00400100", k, a);
            end
        end
    endtask

    task automatic test_jalr();
        logic [31:0] a;
        bit          ok;
        walk_to(0, ok);
        fetch_one($urandom, 0, a, ok);
        retire_one(0, 0, 1, 1, 0, 32'h0040_0203, 0);
        n_checks++;
        if (pc_misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL jalr_misalign_set: got %b expected 1", pc_misalign);
        end
`ifdef MIPS_DELAY_SLOT_EN
        fetch_one($urandom, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h0040_0004) begin
            n_fail++;
            $display("FAIL jalr_slot: got %h expected 00400004", a);
        end
        retire_one(0, 0, 0, 0, 0, 32'h0, 0);
`endif
        fetch_one($urandom, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h0040_0200) begin
            n_fail++;
            $display("FAIL jalr_target: got %h expected 00400200", a);
        end
        retire_one(1, 0, 0, 0, 0, 32'h0, 0);
        fetch_one($urandom, 2, a, ok);
        retire_one(0, 0, 0, 0, 0, 32'h0, 0);
        n_checks++;
        if (pc_misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL jalr_misalign_sticky: got %b expected 1", pc_misalign);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_misalign_clear: got %b expected 0", pc_misalign);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_halt();
        logic [31:0] a;
        bit          ok;
        int          busy;
        walk_to(3, ok);
        fetch_one(32'h0000_000C, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h0040_000C) begin
            n_fail++;
            $display("FAIL halt_src: got %h expected 0040000c", a);
        end
        retire_one(0, 0, 0, 0, 0, 32'h0, 1);
        busy = 0;
        for (int i = 0; i < 30; i++) begin
            inst_ack      = 1'($urandom);
            halt          = 1'($urandom);
            imem.imem_rdy = 1'($urandom);
            @(negedge clk);
            if (imem.imem_req !== 1'b0 || inst_valid !== 1'b0) busy++;
        end
        n_checks++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL halt_idle: %0d active cycles expected 0", busy);
        end
        apply_reset();
        fetch_one($urandom, 0, a, ok);
        n_checks++;
        if (!ok || a !== RESET_PC) begin
            n_fail++;
            $display("FAIL halt_restart: got %h ok=%0d expected %h", a, ok, RESET_PC);
        end
        retire_one(0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_rst_mid_request();
        logic [31:0] a;
        bit          ok;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            imem.imem_rdy = 1'b0;
            @(negedge clk);
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h expected 1/%h",
                         i, imem.imem_req, imem.imem_addr, RESET_PC);
            end
        end
        rst             = 1'b1;
        imem.imem_rdy   = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (imem.imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_req: req=%b valid=%b expected 0/0", imem.imem_req, inst_valid);
        end
        rst           = 1'b0;
        imem.imem_rdy = 1'b0;
        model_reset();
        fetch_one(32'h1234_5678, 0, a, ok);
        n_checks++;
        if (!ok || a !== RESET_PC || inst !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rst_restart: addr=%h inst=%h expected %h/12345678", a, inst, RESET_PC);
        end
        retire_one(0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] exp_pc;
        logic [31:0] jr;
        bit          ok;
        bit          isj;
        bit          jalr;
        bit          isb;
        bit          brt;
        apply_reset();
        for (int k = 0; k < 150; k++) begin
            exp_pc = m_pc;
            w      = $urandom;
            fetch_one(w, $urandom_range(0, 3), a, ok);
            n_checks++;
            if (!ok || a !== exp_pc || a[1:0] !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_addr[%0d]: got %h ok=%0d expected %h", k, a, ok, exp_pc);
            end
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== w || inst_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL rand_inst[%0d]: valid=%b inst=%h pc=%h expected 1/%h/%h",
                         k, inst_valid, inst, inst_pc, w, exp_pc);
            end
            isj  = ($urandom_range(0, 99) < 15);
            jalr = isj && ($urandom_range(0, 1) == 1);
            isb  = ($urandom_range(0, 99) < 35);
            brt  = 1'($urandom);
            jr   = $urandom;
            if ($urandom_range(0, 99) < 85) jr[1:0] = 2'b00;
            retire_one($urandom_range(0, 2), isb, isj, jalr, brt, jr, 0);
            n_checks++;
            if (pc_misalign !== m_misalign) begin
                n_fail++;
                $display("FAIL rand_misalign[%0d]: got %b expected %b", k, pc_misalign, m_misalign);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        imem.imem_rdy   = 1'b0;
        imem.imem_rdata = '0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_jalr();
        test_halt();
        test_rst_mid_request();
        test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
